target_hold_scorer: RTL and testbench
=====================================

TARGET_HOLD_SCORER -- requirements
Module: target_hold_scorer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- POS_W, 16: signed position width.
- NUM_LEDS, 8: target slots; LED_W = clog2(NUM_LEDS).
- LED_SPAN, 100: position units per slot.
- HOLD_CYCLES, 4: consecutive in-window cycles needed to score.
- ROUND_CYCLES, 64: level-0 round timeout.
- SCORE_W, 8: score/round counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-low.
- start_round, in, 1: begin round.
- abort, in, 1: cancel round.
- reset_ponto, in, 1: clear score and round count.
- position_led, in, LED_W: target slot.
- nivel_dificuldade, in, 2: level 0..3.
- current_position, in, POS_W: signed pendulum position.
- ganhou_ponto, out, 1: one-cycle win pulse.
- perdeu_ponto, out, 1: one-cycle loss pulse.
- pontuacao, out, SCORE_W: score.
- contador_jogo, out, SCORE_W: completed rounds.
- busy, out, 1: high in ARM/TRACK/RESULT.
- in_window, out, 1: registered hit flag.

Function
REQ-003 FSM SHALL have states IDLE, ARM, TRACK, RESULT.
REQ-004 In IDLE, start_round=1 SHALL go to ARM next cycle; start_round SHALL be ignored in every other state.
REQ-005 In ARM, the block SHALL latch the slot (values >= NUM_LEDS clamped to NUM_LEDS-1) and the level, clear the hold and round timers, and go to TRACK.
REQ-006 Target SHALL be -(NUM_LEDS*LED_SPAN)/2 + slot*LED_SPAN + LED_SPAN/2, computed at POS_W+2 signed bits with no overflow.
REQ-007 Tolerance SHALL be LED_SPAN >> level.
REQ-008 Round limit SHALL be ROUND_CYCLES >> level, minimum 1.
REQ-009 The hit condition SHALL be |current_position - target| <= tolerance, evaluated each TRACK cycle.
REQ-010 The hold counter SHALL increment on a hit and reset to 0 on a miss.
REQ-011 The round timer SHALL increment every TRACK cycle.
REQ-012 Win SHALL be a hit with hold == HOLD_CYCLES-1. Timeout SHALL be round timer == limit-1 without a win.
- If both occur in the same cycle, win SHALL take priority.
REQ-013 On win or timeout, the FSM SHALL go to RESULT.
REQ-014 RESULT SHALL last exactly one cycle, then return to IDLE. During RESULT:
- ganhou_ponto or perdeu_ponto SHALL be 1 (never both).
- contador_jogo SHALL increment, wrapping modulo 2^SCORE_W.
REQ-015 On win, pontuacao SHALL increment, saturating at 2^SCORE_W-1.
REQ-016 abort=1 in ARM or TRACK SHALL return to IDLE next cycle with no pulse and no counter change.
- abort in IDLE or RESULT SHALL have no effect.
REQ-017 reset_ponto=1 SHALL clear pontuacao and contador_jogo next cycle and SHALL override a same-cycle increment. The FSM SHALL be unaffected.
REQ-018 All outputs SHALL be registered. Latency: start_round sampled at cycle t puts TRACK active at t+2; the earliest pulse is at t+2+HOLD_CYCLES.
REQ-019 in_window SHALL mirror the hit condition in TRACK and be 0 in other states.

Reset
REQ-020 reset=0 at a rising edge SHALL, on that edge:
- force IDLE;
- zero all counters, pulses, busy, in_window, pontuacao and contador_jogo;
- regardless of other inputs, including mid-round.
REQ-021 After reset releases, the first start_round SHALL be honoured.

Verification (defaults)
REQ-022 Win: slot=5, level=0, position=150 held → ganhou_ponto at t+6, pontuacao 0→1, contador_jogo 0→1.
REQ-023 Tolerance edges:
- Level 2, slot 5: position 175 wins; 176 times out at round cycle 15 with perdeu_ponto.
REQ-024 Hold break: in-window 3 cycles, out 1, then in 4 → win 8 cycles after TRACK entry.
REQ-025 Saturation and clear:
- Preload 255 wins → pontuacao stays 255 after the next win.
- reset_ponto during RESULT → pontuacao=0, contador_jogo=0.
REQ-026 Boundaries:
- Win and timeout in the same cycle (level 3, limit 8, HOLD 8) → win only.
- abort in TRACK → no pulse.
- reset=0 in TRACK → all outputs 0 next cycle.

Source files
------------

// File: rtl/target_hold_scorer.sv
// Pendulum target game scorer: arms on a chosen LED slot, tracks whether the position stays
// inside a level-dependent window for HOLD_CYCLES in a row, and keeps score and round count.
module target_hold_scorer #(
    parameter int  POS_W        = 16,
    parameter int  NUM_LEDS     = 8,
    parameter int  LED_SPAN     = 100,
    parameter int  HOLD_CYCLES  = 4,
    parameter int  ROUND_CYCLES = 64,
    parameter int  SCORE_W      = 8,
    localparam int LED_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_round,
    input  logic                    abort,
    input  logic                    reset_ponto,
    input  logic [LED_W-1:0]        position_led,
    input  logic [1:0]              nivel_dificuldade,
    input  logic signed [POS_W-1:0] current_position,
    output logic                    ganhou_ponto,
    output logic                    perdeu_ponto,
    output logic [SCORE_W-1:0]      pontuacao,
    output logic [SCORE_W-1:0]      contador_jogo,
    output logic                    busy,
    output logic                    in_window
);
    localparam int TW     = POS_W + 2;
    localparam int DW     = POS_W + 3;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int RT_W   = $clog2(ROUND_CYCLES + 1);
    localparam int OFFSET = LED_SPAN / 2 - (NUM_LEDS * LED_SPAN) / 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_TRACK  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    function automatic int round_limit(input int lvl);
        int lim;
        lim = ROUND_CYCLES >> lvl;
        return (lim < 1) ? 1 : lim;
    endfunction

    logic [1:0]         state_reg, state_next;
    logic [LED_W-1:0]   slot_reg;
    logic [1:0]         level_reg;
    logic [HOLD_W-1:0]  hold_reg;
    logic [RT_W-1:0]    round_reg;
    logic               ganhou_reg, perdeu_reg, busy_reg, in_window_reg;
    logic [SCORE_W-1:0] score_reg, count_reg;

    logic [LED_W-1:0]     slot_clamped;
    logic signed [TW-1:0] target;
    logic [DW-1:0]        diff, abs_diff, tol;
    logic [RT_W-1:0]      limit_m1;
    logic                 hit, win, timeout, ending;

    always_comb begin
        slot_clamped = position_led;
        if ({1'b0, position_led} >= (LED_W + 1)'(NUM_LEDS))
            slot_clamped = LED_W'(NUM_LEDS - 1);
    end

    // Window test done at POS_W+3 bits so the subtraction can never wrap.
    always_comb begin
        target   = TW'(OFFSET) + TW'(slot_reg) * TW'(LED_SPAN);
        diff     = {{3{current_position[POS_W-1]}}, current_position} - {target[TW-1], target};
        abs_diff = diff[DW-1] ? (~diff + DW'(1)) : diff;
        tol      = DW'(LED_SPAN >> level_reg);
        hit      = (abs_diff <= tol);
        limit_m1 = RT_W'(round_limit(int'(level_reg)) - 1);
    end

    always_comb begin
        win        = (state_reg == S_TRACK) && hit && (hold_reg == HOLD_W'(HOLD_CYCLES - 1));
        timeout    = (state_reg == S_TRACK) && !win && (round_reg == limit_m1);
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start_round) state_next = S_ARM;
            S_ARM:    state_next = abort ? S_IDLE : S_TRACK;
            S_TRACK: begin
                if (abort)                state_next = S_IDLE;
                else if (win || timeout)  state_next = S_RESULT;
            end
            default:  state_next = S_IDLE;
        endcase
        ending = (state_reg == S_TRACK) && (state_next == S_RESULT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            slot_reg      <= '0;
            level_reg     <= '0;
            hold_reg      <= '0;
            round_reg     <= '0;
            ganhou_reg    <= 1'b0;
            perdeu_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            in_window_reg <= 1'b0;
            score_reg     <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= (state_next != S_IDLE);
            ganhou_reg    <= ending && win;
            perdeu_reg    <= ending && !win;
            // Only flagged while the round keeps tracking, so it reads 0 in RESULT/IDLE.
            in_window_reg <= (state_reg == S_TRACK) && (state_next == S_TRACK) && hit;

            if (state_reg == S_ARM) begin
                slot_reg  <= slot_clamped;
                level_reg <= nivel_dificuldade;
                hold_reg  <= '0;
                round_reg <= '0;
            end else if (state_reg == S_TRACK) begin
                hold_reg  <= hit ? (hold_reg + HOLD_W'(1)) : '0;
                round_reg <= round_reg + RT_W'(1);
            end

            if (reset_ponto) begin
                score_reg <= '0;
                count_reg <= '0;
            end else if (ending) begin
                count_reg <= count_reg + SCORE_W'(1);
                if (win && (score_reg != {SCORE_W{1'b1}}))
                    score_reg <= score_reg + SCORE_W'(1);
            end
        end
    end

    assign ganhou_ponto  = ganhou_reg;
    assign perdeu_ponto  = perdeu_reg;
    assign pontuacao     = score_reg;
    assign contador_jogo = count_reg;
    assign busy          = busy_reg;
    assign in_window     = in_window_reg;

endmodule

// File: tb/tb_target_hold_scorer.sv
// Randomised and directed rounds for target_hold_scorer, checked against a round-level model
// that predicts each round's outcome from the planned position sequence.
module tb_target_hold_scorer;
    localparam int POS_W = 16, NUM_LEDS = 8, LED_SPAN = 100, HOLD = 4, ROUNDC = 64, SCORE_W = 8;
    localparam int LED_W = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start_round = 1'b0, abort = 1'b0, reset_ponto = 1'b0;
    logic [LED_W-1:0] position_led = '0;
    logic [1:0] nivel_dificuldade = '0;
    logic signed [POS_W-1:0] current_position = '0;
    logic ganhou_ponto, perdeu_ponto, busy, in_window;
    logic [SCORE_W-1:0] pontuacao, contador_jogo;

    logic b_start = 1'b0;
    logic [LED_W-1:0] b_led = '0;
    logic [1:0] b_lvl = '0;
    logic signed [POS_W-1:0] b_pos = '0;
    logic b_ganhou, b_perdeu, b_busy, b_inwin;
    logic [SCORE_W-1:0] b_score, b_count;

    always #5 clock = ~clock;

    target_hold_scorer dut (
        .clock(clock), .reset(reset), .start_round(start_round), .abort(abort),
        .reset_ponto(reset_ponto), .position_led(position_led),
        .nivel_dificuldade(nivel_dificuldade), .current_position(current_position),
        .ganhou_ponto(ganhou_ponto), .perdeu_ponto(perdeu_ponto), .pontuacao(pontuacao),
        .contador_jogo(contador_jogo), .busy(busy), .in_window(in_window)
    );

    target_hold_scorer #(.HOLD_CYCLES(8)) dut_b (
        .clock(clock), .reset(reset), .start_round(b_start), .abort(1'b0),
        .reset_ponto(1'b0), .position_led(b_led), .nivel_dificuldade(b_lvl),
        .current_position(b_pos), .ganhou_ponto(b_ganhou), .perdeu_ponto(b_perdeu),
        .pontuacao(b_score), .contador_jogo(b_count), .busy(b_busy), .in_window(b_inwin)
    );

    int n_assert = 0;
    int n_fail = 0;
    int exp_score = 0;
    int exp_cnt = 0;
    int pos_arr[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tgt(input int slot);
        int s;
        s = (slot >= NUM_LEDS) ? NUM_LEDS - 1 : slot;
        return -(NUM_LEDS * LED_SPAN) / 2 + s * LED_SPAN + LED_SPAN / 2;
    endfunction

    function automatic int lim_of(input int lvl);
        int l;
        l = ROUNDC >> lvl;
        return (l < 1) ? 1 : l;
    endfunction

    function automatic bit is_hit(input int p, input int slot, input int lvl);
        int d;
        d = p - tgt(slot);
        if (d < 0) d = -d;
        return d <= (LED_SPAN >> lvl);
    endfunction

    task automatic fill(input int v);
        for (int i = 0; i < 64; i++) pos_arr[i] = v;
    endtask

    task automatic fill_random(input int slot, input int lvl);
        int t, tol;
        t = tgt(slot);
        tol = LED_SPAN >> lvl;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 9) == 0)
                pos_arr[i] = t + (($urandom_range(0, 1) == 1) ? 1 : -1) * (tol + 1 + int'($urandom_range(0, 300)));
            else
                pos_arr[i] = t + int'($urandom_range(0, 2 * tol + 2)) - tol - 1;
        end
    endtask

    // rp_mode: 0 none, 1 reset_ponto in the deciding TRACK cycle, 2 reset_ponto during RESULT
    task automatic do_round(input string tag, input int slot, input int lvl,
                            input int abort_at, input int rp_mode);
        int lim, run, e;
        bit won;
        bit hits[64];
        lim = lim_of(lvl);
        run = 0;
        e = lim - 1;
        won = 1'b0;
        for (int i = 0; i < lim; i++) begin
            hits[i] = is_hit(pos_arr[i], slot, lvl);
            run = hits[i] ? run + 1 : 0;
            if (run == HOLD) begin
                e = i;
                won = 1'b1;
                break;
            end
        end

        start_round = 1'b1;
        position_led = LED_W'(slot);
        nivel_dificuldade = 2'(lvl);
        @(posedge clock); #1;
        start_round = 1'b0;
        current_position = POS_W'(pos_arr[0]);
        @(negedge clock);
        chk({tag, ".arm_busy"}, 32'(busy), 1);
        chk({tag, ".arm_inwin"}, 32'(in_window), 0);
        @(posedge clock); #1;
        for (int i = 0; i <= e; i++) begin
            abort = (i == abort_at);
            reset_ponto = (rp_mode == 1) && (i == e);
            @(negedge clock);
            chk({tag, ".trk_busy"}, 32'(busy), 1);
            chk({tag, ".trk_inwin"}, 32'(in_window), (i > 0 && hits[i-1]) ? 1 : 0);
            chk({tag, ".trk_pulse"}, {30'd0, ganhou_ponto, perdeu_ponto}, 0);
            @(posedge clock); #1;
            abort = 1'b0;
            reset_ponto = 1'b0;
            if (i == abort_at) begin
                @(negedge clock);
                chk({tag, ".abort_busy"}, 32'(busy), 0);
                chk({tag, ".abort_pulse"}, {30'd0, ganhou_ponto, perdeu_ponto}, 0);
                chk({tag, ".abort_score"}, 32'(pontuacao), exp_score);
                chk({tag, ".abort_count"}, 32'(contador_jogo), exp_cnt);
                $display("round %s slot=%0d lvl=%0d aborted at track %0d score=%0d count=%0d",
                         tag, slot, lvl, i, exp_score, exp_cnt);
                return;
            end
            if (i < e) current_position = POS_W'(pos_arr[i+1]);
        end

        if (rp_mode == 1) begin
            exp_score = 0;
            exp_cnt = 0;
        end else begin
            exp_cnt = (exp_cnt + 1) % 256;
            if (won && exp_score < 255) exp_score++;
        end
        reset_ponto = (rp_mode == 2);
        @(negedge clock);
        chk({tag, ".res_win"}, 32'(ganhou_ponto), won ? 1 : 0);
        chk({tag, ".res_loss"}, 32'(perdeu_ponto), won ? 0 : 1);
        chk({tag, ".res_busy"}, 32'(busy), 1);
        chk({tag, ".res_inwin"}, 32'(in_window), 0);
        chk({tag, ".res_score"}, 32'(pontuacao), exp_score);
        chk({tag, ".res_count"}, 32'(contador_jogo), exp_cnt);
        @(posedge clock); #1;
        reset_ponto = 1'b0;
        if (rp_mode == 2) begin
            exp_score = 0;
            exp_cnt = 0;
        end
        @(negedge clock);
        chk({tag, ".idle_pulse"}, {30'd0, ganhou_ponto, perdeu_ponto}, 0);
        chk({tag, ".idle_busy"}, 32'(busy), 0);
        chk({tag, ".idle_score"}, 32'(pontuacao), exp_score);
        chk({tag, ".idle_count"}, 32'(contador_jogo), exp_cnt);
        $display("round %s slot=%0d lvl=%0d %s after %0d track cycles score=%0d count=%0d",
                 tag, slot, lvl, won ? "won" : "lost", e + 1, exp_score, exp_cnt);
    endtask

    initial begin
        int slot, lvl, ab;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_outputs", {26'd0, ganhou_ponto, perdeu_ponto, busy, in_window, b_ganhou, b_busy}, 0);
        chk("rst_score", 32'(pontuacao), 0);
        chk("rst_count", 32'(contador_jogo), 0);
        reset = 1'b1;

        fill(150);
        do_round("win_basic", 5, 0, -1, 0);
        fill(175);
        do_round("tol_175", 5, 2, -1, 0);
        fill(176);
        do_round("tol_176", 5, 2, -1, 0);
        fill(150);
        pos_arr[3] = 400;
        do_round("hold_break", 5, 0, -1, 0);
        fill(150);
        do_round("abort_trk", 5, 0, 2, 0);

        for (int r = 0; r < 40; r++) begin
            slot = int'($urandom_range(0, NUM_LEDS - 1));
            lvl = int'($urandom_range(0, 3));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
            fill_random(slot, lvl);
            do_round("rand", slot, lvl, ab, 0);
        end

        fill(tgt(2));
        do_round("rp_same_cycle", 2, 1, -1, 1);
        fill(tgt(6));
        do_round("win_again", 6, 0, -1, 0);
        fill(tgt(6));
        do_round("rp_in_result", 6, 0, -1, 2);

        for (int r = 0; r < 256; r++) begin
            slot = int'($urandom_range(0, NUM_LEDS - 1));
            fill(tgt(slot));
            do_round("sat", slot, 3, -1, 0);
        end
        chk("sat_final", 32'(pontuacao), 255);

        fill(tgt(3));
        start_round = 1'b1;
        position_led = 3'd3;
        nivel_dificuldade = 2'd0;
        @(posedge clock); #1;
        start_round = 1'b0;
        current_position = POS_W'(pos_arr[0]);
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock);
        chk("pre_reset_inwin", 32'(in_window), 1);
        reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_reset_flags", {28'd0, ganhou_ponto, perdeu_ponto, busy, in_window}, 0);
        chk("mid_reset_score", 32'(pontuacao), 0);
        chk("mid_reset_count", 32'(contador_jogo), 0);
        $display("round mid_reset: reset asserted during TRACK");
        reset = 1'b1;
        exp_score = 0;
        exp_cnt = 0;
        fill(tgt(1));
        do_round("after_reset", 1, 0, -1, 0);

        b_pos = POS_W'(tgt(5));
        b_led = 3'd5;
        b_lvl = 2'd3;
        b_start = 1'b1;
        @(posedge clock); #1;
        b_start = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("tie_trk_pulse", {30'd0, b_ganhou, b_perdeu}, 0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("tie_win", 32'(b_ganhou), 1);
        chk("tie_loss", 32'(b_perdeu), 0);
        chk("tie_score", 32'(b_score), 1);
        chk("tie_count", 32'(b_count), 1);
        $display("round tie: HOLD=8 level 3 win/timeout coincide");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
